// File: rtl/adder_pkg.sv
// Shared types and constants for the pipelined carry-chained adder.
// Default geometry is 16 bits split into four 4-bit chunks.
package adder_pkg;

  localparam int unsigned ADDER_WIDTH  = 16;
  localparam int unsigned ADDER_STAGES = 4;

  // Width of one carry-chain chunk handled by a single pipeline stage.
  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  // Stage register layout for the default geometry. Low chunks of res hold
  // finished sum bits and high chunks still hold operand A. opb holds operand B
  // chunks that have not been consumed yet.
  typedef struct packed {
    logic                   valid;
    logic                   carry;
    logic [ADDER_WIDTH-1:0] res;
    logic [ADDER_WIDTH-1:0] opb;
  } stage_reg_t;

endpackage

// File: rtl/pipe_adder_if.sv
// Producer/consumer bus of pipe_adder. The producer side pushes operands with
// in_valid/in_ready, and the consumer side pops results with out_valid/out_ready.
// The ovf signal exists only when PIPE_ADDER_OVF_EN is defined.
interface pipe_adder_if
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef PIPE_ADDER_OVF_EN
  logic             ovf;
`endif

  // Environment view: drives operands and result back-pressure.
  modport master (
`ifdef PIPE_ADDER_OVF_EN
    input  ovf,
`endif
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  // Adder view.
  modport slave (
`ifdef PIPE_ADDER_OVF_EN
    output ovf,
`endif
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
  );

endinterface

// File: rtl/adder_chunk.sv
// One combinational slice of the carry chain: {cout, s_k} = a_k + b_k + cin.
module adder_chunk #(
  parameter int unsigned CW = 4
) (
  input  logic [CW-1:0] a_k,
  input  logic [CW-1:0] b_k,
  input  logic          cin,
  output logic [CW-1:0] s_k,
  output logic          cout
);

  assign {cout, s_k} = {1'b0, a_k} + {1'b0, b_k} + {{CW{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder_chk.sv
// Elaboration-time sanity checks on the pipe_adder geometry.
module pipe_adder_chk #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) ();

  if (STAGES < 1) begin : g_bad_stages
    $error("pipe_adder: STAGES must be at least 1");
  end else if ((WIDTH % STAGES) != 0) begin : g_bad_width
    $error("pipe_adder: WIDTH must be a multiple of STAGES");
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined carry-chained adder with valid/ready on both sides.
// Stage k resolves chunk k of the sum and passes its carry to stage k+1.
// One global advance enable moves or freezes the whole pipe, and bubbles are
// kept in place. Optional feature: PIPE_ADDER_OVF_EN adds a registered signed
// overflow output.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = ADDER_WIDTH,
  parameter int unsigned STAGES = ADDER_STAGES
) (
  input logic         clk,
  input logic         rst_n,
  pipe_adder_if.slave bus
);

  localparam int unsigned CW = chunk_width(WIDTH, STAGES);

  // Same layout as adder_pkg::stage_reg_t, sized for this instance.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] opb;
  } stage_t;

  stage_t        stage_q [STAGES];
  stage_t        stage_d [STAGES];
  stage_t        src     [STAGES];
  logic [CW-1:0] ck_sum  [STAGES];
  logic          ck_cout [STAGES];
  logic          adv;

  pipe_adder_chk #(.WIDTH(WIDTH), .STAGES(STAGES)) u_chk ();

  // The pipe moves unless a finished result is waiting on the consumer.
  assign adv           = !stage_q[STAGES-1].valid || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = stage_q[STAGES-1].valid;
  assign bus.sum       = stage_q[STAGES-1].res;
  assign bus.c_out     = stage_q[STAGES-1].carry;

  // Select each stage's source: bus operands for stage 0, predecessor register otherwise.
  always_comb begin
    src[0].valid = bus.in_valid && adv;
    src[0].carry = bus.c_in;
    src[0].res   = bus.a;
    src[0].opb   = bus.b;
    for (int k = 1; k < STAGES; k++) begin
      src[k] = stage_q[k-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_chunk
    adder_chunk #(.CW(CW)) u_chunk (
      .a_k  (src[g].res[g*CW +: CW]),
      .b_k  (src[g].opb[g*CW +: CW]),
      .cin  (src[g].carry),
      .s_k  (ck_sum[g]),
      .cout (ck_cout[g])
    );
  end

  // Next state of each stage: splice in the resolved chunk, or hold on a stall.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (adv) begin
        stage_d[k]                   = src[k];
        stage_d[k].res[k*CW +: CW]   = ck_sum[k];
        stage_d[k].carry             = ck_cout[k];
      end else begin
        stage_d[k] = stage_q[k];
      end
    end
  end

  // Stage registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow: operands agree in sign but the resolved MSB disagrees.
  always_comb begin
    if (adv) begin
      ovf_d = (src[STAGES-1].res[WIDTH-1] == src[STAGES-1].opb[WIDTH-1]) &&
              (ck_sum[STAGES-1][CW-1] != src[STAGES-1].res[WIDTH-1]);
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register, aligned with the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule
